// File: rtl/memory_bus_pkg.sv
// Shared request/ID types and the round-robin pick helper used by memory_bus_arbiter.
package memory_bus_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 24;
    localparam int ID_WIDTH      = 4;
    localparam int MAX_MASTERS   = 2 ** ID_WIDTH;

    typedef logic [ID_WIDTH-1:0] bus_id_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
        logic                     write;
    } bus_req_t;

    // Scanning from the far end down lets the closest eligible index at or after ptr overwrite the rest.
    function automatic int rr_pick(input logic [MAX_MASTERS-1:0] eligible, input int ptr, input int numMasters);
        int idx;
        rr_pick = 0;
        for (int k = MAX_MASTERS - 1; k >= 0; k--) begin
            if (k < numMasters) begin
                idx = ptr + k;
                if (idx >= numMasters) begin
                    idx = idx - numMasters;
                end
                if (eligible[ID_WIDTH'(idx)]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner selection plus the rotating priority pointer.
module rr_arbiter
    import memory_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int PTR_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   advance,
    input  logic [NUM_MASTERS-1:0] eligible,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   anyGrant,
    output logic [PTR_WIDTH-1:0]   winner
);

    logic [PTR_WIDTH-1:0]   rrPtr;
    logic [MAX_MASTERS-1:0] eligibleWide;

    always_comb begin
        eligibleWide = '0;
        eligibleWide[NUM_MASTERS-1:0] = eligible;
        winner = PTR_WIDTH'(rr_pick(eligibleWide, int'(rrPtr), NUM_MASTERS));
        anyGrant = advance && (|eligible);
        grant = '0;
        if (anyGrant) begin
            grant[winner] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rrPtr <= '0;
        end else if (anyGrant) begin
            rrPtr <= (winner == PTR_WIDTH'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one MemoryBus slave port among NUM_MASTERS ray-memory masters with round-robin grant and per-master read caps.
// Optional build macro ARB_PERF_COUNTERS_EN adds per-master grantCount/stallCount output ports.
module memory_bus_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int DATA_WIDTH      = memory_bus_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH   = memory_bus_pkg::ADDRESS_WIDTH,
    parameter int ID_WIDTH        = memory_bus_pkg::ID_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_MASTERS-1:0]             upValid,
    output logic [NUM_MASTERS-1:0]             upTaken,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] upAddress,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  upData,
    input  logic [NUM_MASTERS-1:0]             upWrite,
    output logic [NUM_MASTERS-1:0]             upRspValid,
    input  logic [NUM_MASTERS-1:0]             upRspTaken,
    output logic [DATA_WIDTH-1:0]              upRspData,
    output logic                               msValid,
    input  logic                               msTaken,
    output logic [ID_WIDTH-1:0]                msID,
    output logic [ADDRESS_WIDTH-1:0]           msAddress,
    output logic [DATA_WIDTH-1:0]              msData,
    output logic                               msWrite,
    input  logic                               smValid,
    output logic                               smTaken,
    input  logic [ID_WIDTH-1:0]                smID,
    input  logic [DATA_WIDTH-1:0]              smData,
    output logic                               idErr
`ifdef ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0]                        grantCount [NUM_MASTERS],
    output logic [31:0]                        stallCount [NUM_MASTERS]
`endif
);

    import memory_bus_pkg::*;

    localparam int PTR_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [ID_WIDTH:0]    ID_LIMIT = (ID_WIDTH + 1)'(NUM_MASTERS);

    logic [CNT_WIDTH-1:0]   cnt [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] rspHit;
    logic [NUM_MASTERS-1:0] readIssue;
    logic                   anyGrant;
    logic                   slotFree;
    logic                   smIdLegal;
    logic [PTR_WIDTH-1:0]   winner;
    bus_req_t               msReq;

    always_comb begin
        slotFree = !msValid || msTaken;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = upValid[i] && (upWrite[i] || cnt[i] < CNT_MAX);
        end
    end

    rr_arbiter #(
        .NUM_MASTERS(NUM_MASTERS),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_rr (
        .clock   (clock),
        .reset   (reset),
        .advance (slotFree),
        .eligible(eligible),
        .grant   (grant),
        .anyGrant(anyGrant),
        .winner  (winner)
    );

    assign upTaken   = grant;
    assign msAddress = msReq.address;
    assign msData    = msReq.data;
    assign msWrite   = msReq.write;
    assign upRspData = smData;

    // The slot reloads only when it is empty or being drained this cycle, so a stalled request holds steady.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msValid <= 1'b0;
            msReq   <= '0;
            msID    <= '0;
        end else if (slotFree) begin
            msValid <= anyGrant;
            if (anyGrant) begin
                msReq.address <= upAddress[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                msReq.data    <= upData[winner*DATA_WIDTH +: DATA_WIDTH];
                msReq.write   <= upWrite[winner];
                msID          <= ID_WIDTH'(winner);
            end
        end
    end

    // Responses with an ID no master owns are swallowed so the slave never blocks on them.
    always_comb begin
        smIdLegal  = {1'b0, smID} < ID_LIMIT;
        smTaken    = !smIdLegal;
        upRspValid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (smID == ID_WIDTH'(i)) begin
                upRspValid[i] = smValid;
                smTaken       = upRspTaken[i];
            end
        end
        rspHit    = upRspValid & {NUM_MASTERS{smTaken}};
        readIssue = grant & ~upWrite;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (readIssue[i] && !rspHit[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!readIssue[i] && rspHit[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_cntCheck
        assert property (@(posedge clock) disable iff (!reset) !(rspHit[g] && cnt[g] == '0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idErr <= 1'b0;
        end else if (smValid && !smIdLegal) begin
            idErr <= 1'b1;
        end
    end

`ifdef ARB_PERF_COUNTERS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                grantCount[i] <= '0;
                stallCount[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant[i] && grantCount[i] != '1) begin
                    grantCount[i] <= grantCount[i] + 1'b1;
                end
                if (upValid[i] && !grant[i] && stallCount[i] != '1) begin
                    stallCount[i] <= stallCount[i] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: grant order, read caps, stalls, response routing, bad IDs and async reset.
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
module tb_memory_bus_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 24;
    localparam int IW = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [NM-1:0]    upValid;
    logic [NM-1:0]    upTaken;
    logic [NM*AW-1:0] upAddress;
    logic [NM*DW-1:0] upData;
    logic [NM-1:0]    upWrite;
    logic [NM-1:0]    upRspValid;
    logic [NM-1:0]    upRspTaken;
    logic [DW-1:0]    upRspData;
    logic             msValid;
    logic             msTaken;
    logic [IW-1:0]    msID;
    logic [AW-1:0]    msAddress;
    logic [DW-1:0]    msData;
    logic             msWrite;
    logic             smValid;
    logic             smTaken;
    logic [IW-1:0]    smID;
    logic [DW-1:0]    smData;
    logic             idErr;
`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0]      grantCount [NM];
    logic [31:0]      stallCount [NM];
`endif

    int assertCount = 0;
    int failCount   = 0;
    int grantOrder [5] = '{0, 1, 2, 3, 0};

    always #5 clock = ~clock;

    memory_bus_arbiter #(
        .NUM_MASTERS    (NM),
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .ID_WIDTH       (IW),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .upValid   (upValid),
        .upTaken   (upTaken),
        .upAddress (upAddress),
        .upData    (upData),
        .upWrite   (upWrite),
        .upRspValid(upRspValid),
        .upRspTaken(upRspTaken),
        .upRspData (upRspData),
        .msValid   (msValid),
        .msTaken   (msTaken),
        .msID      (msID),
        .msAddress (msAddress),
        .msData    (msData),
        .msWrite   (msWrite),
        .smValid   (smValid),
        .smTaken   (smTaken),
        .smID      (smID),
        .smData    (smData),
        .idErr     (idErr)
`ifdef ARB_PERF_COUNTERS_EN
        ,
        .grantCount(grantCount),
        .stallCount(stallCount)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input logic [NM-1:0] valid, input logic [NM-1:0] write, input logic taken);
        upValid = valid;
        upWrite = write;
        msTaken = taken;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        upValid    = '0;
        upWrite    = '0;
        upAddress  = '0;
        upData     = '0;
        upRspTaken = '0;
        msTaken    = 1'b0;
        smValid    = 1'b0;
        smID       = '0;
        smData     = '0;
        #3;
        checkOutput("reset_msValid", msValid, 0);
        checkOutput("reset_msID", msID, 0);
        checkOutput("reset_msAddress", msAddress, 0);
        checkOutput("reset_idErr", idErr, 0);
        checkOutput("reset_upTaken", upTaken, 0);
        tick();
        reset = 1'b1;

        $display("[TB] single write from master 0");
        upAddress[0 +: AW] = 32'h10;
        upData[0 +: DW]    = 24'hABCDEF;
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        #1;
        checkOutput("t1_upTaken", upTaken, 4'b0001);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        #1;
        checkOutput("t1_msValid", msValid, 1);
        checkOutput("t1_msID", msID, 0);
        checkOutput("t1_msAddress", msAddress, 32'h10);
        checkOutput("t1_msData", msData, 24'hABCDEF);
        checkOutput("t1_msWrite", msWrite, 1);
        checkOutput("t1_upTakenIdle", upTaken, 0);
        tick();
        #1;
        checkOutput("t1_msValidDrained", msValid, 0);

        $display("[TB] four masters contending");
        doReset();
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("t2_grant%0d", k), upTaken, 64'(4'b0001 << grantOrder[k]));
            if (k > 0) begin
                checkOutput($sformatf("t2_msID%0d", k), msID, 64'(grantOrder[k-1]));
            end
            tick();
        end
        msTaken = 1'b0;
        #1;
        checkOutput("t2_noGrantStall", upTaken, 0);
        checkOutput("t2_msIDLast", msID, 0);
        tick();
        #1;
        checkOutput("t2_noGrantStall2", upTaken, 0);
        checkOutput("t2_msValidHeld", msValid, 1);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        #1;
        checkOutput("t2_msValidDrained", msValid, 0);

        $display("[TB] read cap on master 2");
        upAddress[2*AW +: AW] = 32'h200;
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("t3_read%0d", k), upTaken, 4'b0100);
            tick();
        end
        #1;
        checkOutput("t3_fifthBlocked", upTaken, 0);
        tick();
        #1;
        checkOutput("t3_fifthBlocked2", upTaken, 0);
        checkOutput("t3_msValidIdle", msValid, 0);
        smValid    = 1'b1;
        smID       = 4'd2;
        smData     = 24'h123456;
        upRspTaken = 4'b0000;
        #1;
        checkOutput("t3_rspValid", upRspValid, 4'b0100);
        checkOutput("t3_rspData", upRspData, 24'h123456);
        checkOutput("t3_smTakenHeld", smTaken, 0);
        tick();
        #1;
        checkOutput("t3_stillBlocked", upTaken, 0);
        upRspTaken = 4'b0100;
        #1;
        checkOutput("t3_smTaken", smTaken, 1);
        checkOutput("t3_blockedDuringRsp", upTaken, 0);
        tick();
        smValid    = 1'b0;
        upRspTaken = 4'b0000;
        #1;
        checkOutput("t3_fifthGranted", upTaken, 4'b0100);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        #1;
        checkOutput("t3_msValid", msValid, 1);
        checkOutput("t3_msID", msID, 2);
        checkOutput("t3_msWrite", msWrite, 0);
        checkOutput("t3_msAddress", msAddress, 32'h200);
        tick();

        $display("[TB] downstream stall with master 1 pending");
        upAddress[0 +: AW]  = 32'h40;
        upAddress[AW +: AW] = 32'h80;
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        #1;
        checkOutput("t4_grant0", upTaken, 4'b0001);
        tick();
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput($sformatf("t4_stallTaken%0d", k), upTaken, 0);
            checkOutput($sformatf("t4_stallAddr%0d", k), msAddress, 32'h40);
            checkOutput($sformatf("t4_stallValid%0d", k), msValid, 1);
            tick();
        end
        msTaken = 1'b1;
        #1;
        checkOutput("t4_releaseGrant", upTaken, 4'b0010);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        #1;
        checkOutput("t4_msID", msID, 1);
        checkOutput("t4_msAddress", msAddress, 32'h80);
        tick();
        #1;
        checkOutput("t4_msValidDrained", msValid, 0);

        $display("[TB] response with unowned ID");
        smValid    = 1'b1;
        smID       = 4'd7;
        upRspTaken = 4'b0000;
        #1;
        checkOutput("t5_smTaken", smTaken, 1);
        checkOutput("t5_noRspValid", upRspValid, 0);
        checkOutput("t5_idErrBefore", idErr, 0);
        tick();
        smValid = 1'b0;
        #1;
        checkOutput("t5_idErrSet", idErr, 1);
        tick();
        #1;
        checkOutput("t5_idErrSticky", idErr, 1);
        doReset();
        #1;
        checkOutput("t5_idErrCleared", idErr, 0);

        $display("[TB] reset in the middle of a stall");
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("t6_read%0d", k), upTaken, 4'b0100);
            tick();
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        #1;
        checkOutput("t6_msValidStalled", msValid, 1);
        reset = 1'b0;
        #1;
        checkOutput("t6_msValidAsync", msValid, 0);
        checkOutput("t6_msIDAsync", msID, 0);
        checkOutput("t6_msAddressAsync", msAddress, 0);
        tick();
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        #1;
        checkOutput("t6_ptrReset", upTaken, 4'b0001);
        tick();
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        #1;
        checkOutput("t6_cntReset", upTaken, 4'b0100);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
